// File: rtl/jedro_1_data_ram.sv
// rtl/jedro_1_data_ram.sv - single-port data RAM with req/gnt/rvalid handshake
// Each access is latched on grant and answered WAIT_CYCLES+1 cycles later.
module jedro_1_data_ram #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [MEM_WORDS];

  logic        acc_we;
  logic [3:0]  acc_be;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic [AW-1:0] acc_widx;
  logic        enter_resp;

  // With WAIT_CYCLES = 0 RESP is entered on the grant edge itself, so the
  // access must be taken from the live inputs rather than the latches.
  assign acc_we    = (state == IDLE) ? we_i    : lat_we;
  assign acc_be    = (state == IDLE) ? be_i    : lat_be;
  assign acc_addr  = (state == IDLE) ? addr_i  : lat_addr;
  assign acc_wdata = (state == IDLE) ? wdata_i : lat_wdata;
  assign acc_widx  = acc_addr[AW+1:2];
  assign acc_err   = (acc_addr[1:0] != 2'b00) ||
                     ({2'b00, acc_addr[31:2]} >= 32'(MEM_WORDS));

  assign gnt_o      = req_i && (state == IDLE) && rstn_i;
  assign rvalid_o   = (state == RESP);
  assign enter_resp = (state_d == RESP);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (gnt_o) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_d = RESP;
        else             cnt_d   = cnt - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_be    <= 4'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      rdata_o   <= 32'd0;
      err_o     <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (gnt_o) begin
        lat_we    <= we_i;
        lat_be    <= be_i;
        lat_addr  <= addr_i;
        lat_wdata <= wdata_i;
      end
      if (enter_resp) begin
        if (acc_err) begin
          rdata_o <= 32'd0;
          err_o   <= 1'b1;
        end else if (acc_we) begin
          rdata_o <= 32'd0;
          err_o   <= 1'b0;
        end else begin
          rdata_o <= mem[acc_widx];
          err_o   <= 1'b0;
        end
      end
    end
  end

  // Memory has no reset so contents survive rstn_i.
  always_ff @(posedge clk_i) begin
    if (enter_resp && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_widx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/jedro_1_data_ram.md
JEDRO_1_DATA_RAM -- requirements
Module: jedro_1_data_ram

Interface
REQ-001 SHALL have parameter: MEM_WORDS, 1024, number of 32-bit words stored.
REQ-002 SHALL have parameter: WAIT_CYCLES, 0, extra latency cycles before response (legal range 0..15).
REQ-003 SHALL have port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rstn_i  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port: req_i  input  1  core requests a data access.
REQ-006 SHALL have port: we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port: be_i  input  4  byte enables for writes; bit n selects wdata_i[8n+7:8n].
REQ-008 SHALL have port: addr_i  input  32  byte address.
REQ-009 SHALL have port: wdata_i  input  32  write data.
REQ-010 SHALL have port: gnt_o  output  1  request accepted this cycle.
REQ-011 SHALL have port: rvalid_o  output  1  response valid, exactly one cycle per accepted request.
REQ-012 SHALL have port: rdata_o  output  32  read data; registered.
REQ-013 SHALL have port: err_o  output  1  access error; qualified by rvalid_o.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive gnt_o = req_i AND (state == IDLE), combinationally; no other grant path.
REQ-016 On a grant: latch addr_i, we_i, be_i, wdata_i; go to RESP if WAIT_CYCLES = 0, else to WAIT with a counter loaded to WAIT_CYCLES-1.
REQ-017 In WAIT: decrement the counter each cycle; go to RESP on the cycle the counter is 0.
REQ-018 In RESP: assert rvalid_o for one cycle, then go to IDLE unconditionally; req_i is ignored in WAIT and RESP.
REQ-019 SHALL assert rvalid_o exactly WAIT_CYCLES+1 cycles after the grant cycle; max throughput is one access per WAIT_CYCLES+2 cycles.
REQ-020 SHALL take the word index from latched addr[31:2].
REQ-021 SHALL flag an error when latched addr[1:0] != 0, or when the word index is >= MEM_WORDS.
REQ-022 Read without error: on the edge entering RESP, load rdata_o with the full stored word (be_i ignored) and clear err_o.
REQ-023 Write without error: on the edge entering RESP, update only the bytes whose be_i bit is 1; set rdata_o to 0 and err_o to 0.
REQ-024 be_i = 4'b0000 write: memory unchanged; normal response with err_o = 0.
REQ-025 Error access: no memory update; on the edge entering RESP set rdata_o to 0 and err_o to 1.
REQ-026 rdata_o and err_o SHALL hold their values until the next response edge.
REQ-027 A read of a word written by the immediately preceding access SHALL return the newly written bytes.

Reset
REQ-028 While rstn_i = 0 (asynchronous assertion): state IDLE, counter 0, rvalid_o 0, rdata_o 0, err_o 0, gnt_o 0.
REQ-029 Reset SHALL NOT clear memory contents.
REQ-030 Reset in WAIT aborts the access: no write, no rvalid_o.
REQ-031 Reset asserted together with the RESP-entry edge: reset wins, and whether the write completes is not guaranteed.
REQ-032 First grant SHALL be possible on the first rising edge after rstn_i deasserts.

Verification
REQ-033 WAIT_CYCLES=0: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> gnt on request cycle; rvalid 1 cycle later; rdata=0xDEADBEEF; err=0.
REQ-034 WAIT_CYCLES=3: write be=4'b0101 with data 0x11223344 over stored 0xAABBCCDD, then read -> rvalid exactly 4 cycles after each grant; rdata=0xAA22CC44.
REQ-035 Read 0x12 (misaligned) and read 0x1000 with MEM_WORDS=1024 -> err=1, rdata=0x0; memory at 0x0 and 0x10 unchanged.
REQ-036 req_i held high for 10 cycles, WAIT_CYCLES=1 -> gnt pulses every 3rd cycle; one rvalid per gnt; no double accept.
REQ-037 WAIT_CYCLES=3, write 0x12345678 to 0x20, rstn_i pulsed low during WAIT -> no rvalid; later read of 0x20 returns the prior contents.
REQ-038 Write be=4'h0 to 0x8, then read -> err=0; prior contents of 0x8 returned unchanged.
